// File: rtl/clint_pkg.sv
// Shared register offsets, bus FSM encoding and byte-merge helper for the clint block.
package clint_pkg;

  localparam logic [15:0] OFF_MSIP        = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

  function automatic logic [31:0] apply_wsel(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wsel);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (wsel[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Free-running 64-bit mtime with prescaler, half-word load ports and registered mtip compare.
module clint_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [31:0] load_data,
  input  logic [63:0] mtimecmp,
  output logic [63:0] mtime,
  output logic        mtip
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          mtip_q, mtip_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == TICK_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    // A bus write to either half suppresses that cycle's increment.
    if (load_lo) mtime_d = {mtime_q[63:32], load_data};
    if (load_hi) mtime_d = {load_data, mtime_q[31:0]};
    mtip_d  = (mtime_q >= mtimecmp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
      mtip_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      mtip_q  <= mtip_d;
    end
  end

  assign mtime = mtime_q;
  assign mtip  = mtip_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor bus responder: msip, mtimecmp, mtime window with one-cycle response.
// Define CLINT_MTIME_LATCH_EN to shadow mtime[63:32] on an mtime-lo read for coherent 64-bit reads.
//   state | meaning
//   IDLE  | waiting for mem_valid; decode, commit writes and latch response on acceptance
//   RESP  | mem_ready high for exactly one cycle; mem_valid ignored
module clint
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wsel,
  input  logic        mem_valid,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        xint_mtip,
  output logic        xint_msip
);

  bus_state_e  state_q, state_d;
  logic        error_q, error_d;
  logic [31:0] rdata_q, rdata_d;
  logic        msip_q, msip_d;
  logic        xint_msip_q, xint_msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;

  logic [63:0] mtime;
  logic        load_lo, load_hi;
  logic [31:0] load_data;
  logic [31:0] mtime_hi_rd;

  logic [15:0] offset;
  logic        base_hit, aligned, mapped, legal, is_write;

  assign offset   = mem_address[15:0];
  assign base_hit = (mem_address[31:16] == BASE_ADDR[31:16]);
  assign aligned  = (mem_address[1:0] == 2'b00);
  assign mapped   = (offset == OFF_MSIP)        || (offset == OFF_MTIMECMP_LO) ||
                    (offset == OFF_MTIMECMP_HI) || (offset == OFF_MTIME_LO)    ||
                    (offset == OFF_MTIME_HI);
  assign legal    = base_hit && aligned && mapped;
  assign is_write = (mem_wsel != 4'b0000);

`ifdef CLINT_MTIME_LATCH_EN
  logic [31:0] shadow_q, shadow_d;
  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime[63:32];
`endif

  always_comb begin
    state_d     = state_q;
    error_d     = 1'b0;
    rdata_d     = '0;
    msip_d      = msip_q;
    xint_msip_d = msip_q;
    mtimecmp_d  = mtimecmp_q;
    load_lo     = 1'b0;
    load_hi     = 1'b0;
    load_data   = '0;
`ifdef CLINT_MTIME_LATCH_EN
    shadow_d    = shadow_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          state_d = ST_RESP;
          if (!legal) begin
            error_d = 1'b1;
          end else if (is_write) begin
            case (offset)
              OFF_MSIP:        if (mem_wsel[0]) msip_d = mem_wdata[0];
              OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = apply_wsel(mtimecmp_q[31:0], mem_wdata, mem_wsel);
              OFF_MTIMECMP_HI: mtimecmp_d[63:32] = apply_wsel(mtimecmp_q[63:32], mem_wdata, mem_wsel);
              OFF_MTIME_LO: begin
                load_lo   = 1'b1;
                load_data = apply_wsel(mtime[31:0], mem_wdata, mem_wsel);
              end
              OFF_MTIME_HI: begin
                load_hi   = 1'b1;
                load_data = apply_wsel(mtime[63:32], mem_wdata, mem_wsel);
              end
              default: ;
            endcase
          end else begin
            case (offset)
              OFF_MSIP:        rdata_d = {31'b0, msip_q};
              OFF_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
              OFF_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
              OFF_MTIME_LO: begin
                rdata_d  = mtime[31:0];
`ifdef CLINT_MTIME_LATCH_EN
                shadow_d = mtime[63:32];
`endif
              end
              OFF_MTIME_HI:    rdata_d = mtime_hi_rd;
              default: ;
            endcase
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      error_q     <= 1'b0;
      rdata_q     <= '0;
      msip_q      <= 1'b0;
      xint_msip_q <= 1'b0;
      mtimecmp_q  <= '1;
`ifdef CLINT_MTIME_LATCH_EN
      shadow_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      error_q     <= error_d;
      rdata_q     <= rdata_d;
      msip_q      <= msip_d;
      xint_msip_q <= xint_msip_d;
      mtimecmp_q  <= mtimecmp_d;
`ifdef CLINT_MTIME_LATCH_EN
      shadow_q    <= shadow_d;
`endif
    end
  end

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_lo   (load_lo),
    .load_hi   (load_hi),
    .load_data (load_data),
    .mtimecmp  (mtimecmp_q),
    .mtime     (mtime),
    .mtip      (xint_mtip)
  );

  assign mem_ready = (state_q == ST_RESP);
  assign mem_error = error_q;
  assign mem_rdata = rdata_q;
  assign xint_msip = xint_msip_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: directed scenarios plus randomized accesses against a reference model.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wsel = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_error;
  logic        xint_mtip;
  logic        xint_msip;

  clint dut (
    .clk         (clk),
    .rst         (rst),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_wsel    (mem_wsel),
    .mem_valid   (mem_valid),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_error   (mem_error),
    .xint_mtip   (xint_mtip),
    .xint_msip   (xint_msip)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n (sampled #1 later) cyc == n.
  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mtime is a value written at some edge plus the edges elapsed since.
  logic            m_msip;
  logic [63:0]     m_cmp;
  logic [63:0]     m_base;
  longint unsigned m_base_cnt;
  logic [31:0]     m_shadow;

  function automatic logic [63:0] mt_after(input longint unsigned k);
    return m_base + 64'(k - m_base_cnt);
  endfunction

  task automatic model_reset(input longint unsigned k);
    m_msip     = 1'b0;
    m_cmp      = '1;
    m_base     = '0;
    m_base_cnt = k;
    m_shadow   = '0;
  endtask

  task automatic model_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                              input longint unsigned r, output logic [31:0] rd, output logic er);
    logic [63:0] mt;
    logic [31:0] mask;
    logic [15:0] off;
    mt   = mt_after(r - 1);
    off  = a[15:0];
    mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
    er   = (a[31:16] != 16'h0200) || (a[1:0] != 2'b00) ||
           !(off inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC});
    rd   = '0;
    if (!er && ws == 4'b0000) begin
      case (off)
        16'h0000: rd = {31'b0, m_msip};
        16'h4000: rd = m_cmp[31:0];
        16'h4004: rd = m_cmp[63:32];
        16'hBFF8: begin rd = mt[31:0]; m_shadow = mt[63:32]; end
`ifdef CLINT_MTIME_LATCH_EN
        16'hBFFC: rd = m_shadow;
`else
        16'hBFFC: rd = mt[63:32];
`endif
        default: ;
      endcase
    end else if (!er) begin
      case (off)
        16'h0000: if (ws[0]) m_msip = wd[0];
        16'h4000: m_cmp[31:0]  = (m_cmp[31:0] & ~mask) | (wd & mask);
        16'h4004: m_cmp[63:32] = (m_cmp[63:32] & ~mask) | (wd & mask);
        16'hBFF8: begin m_base = {mt[63:32], (mt[31:0] & ~mask) | (wd & mask)}; m_base_cnt = r; end
        16'hBFFC: begin m_base = {(mt[63:32] & ~mask) | (wd & mask), mt[31:0]}; m_base_cnt = r; end
        default: ;
      endcase
    end
  endtask

  // One bus transaction; caller sits #1 after a clock edge with the DUT idle.
  logic [31:0]     b_rd;
  logic            b_er, b_r1, b_r2, b_xm1, b_xm2, b_mt2;
  longint unsigned b_acc;

  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    mem_address = a;
    mem_wdata   = wd;
    mem_wsel    = ws;
    mem_valid   = 1'b1;
    @(posedge clk); #1;
    b_acc = cyc;
    b_r1  = mem_ready;
    b_rd  = mem_rdata;
    b_er  = mem_error;
    b_xm1 = xint_msip;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    b_r2  = mem_ready;
    b_xm2 = xint_msip;
    b_mt2 = xint_mtip;
  endtask

  logic [31:0] e_rd;
  logic        e_er;

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
    n_cmp++; if (mem_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", mem_error); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
    n_cmp++; if (xint_mtip !== 1'b0) begin n_bad++; $display("FAIL reset_mtip: got %b want 0", xint_mtip); end
    n_cmp++; if (xint_msip !== 1'b0) begin n_bad++; $display("FAIL reset_msip: got %b want 0", xint_msip); end
    model_reset(cyc);
    rst = 1'b0;
  endtask

  task automatic test_mtime_read();
    repeat (10) @(posedge clk);
    #1;
    bus(32'h0200_BFF8, 32'h0, 4'h0);
    model_access(32'h0200_BFF8, 32'h0, 4'h0, b_acc, e_rd, e_er);
    n_cmp++; if (b_r1 !== 1'b1) begin n_bad++; $display("FAIL mtime_rd_ready: got %b want 1", b_r1); end
    n_cmp++; if (b_r2 !== 1'b0) begin n_bad++; $display("FAIL mtime_rd_ready_once: got %b want 0", b_r2); end
    n_cmp++; if (b_er !== 1'b0) begin n_bad++; $display("FAIL mtime_rd_error: got %b want 0", b_er); end
    n_cmp++; if (b_rd !== 32'd10) begin n_bad++; $display("FAIL mtime_rd_value: got %0d want 10", b_rd); end
  endtask

  task automatic test_mtip();
    logic [31:0] a [4];
    logic [31:0] d [4];
    logic        exp_mtip;
    a = '{32'h0200_4004, 32'h0200_4000, 32'h0200_BFFC, 32'h0200_BFF8};
    d = '{32'h0, 32'd20, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      bus(a[i], d[i], 4'hF);
      model_access(a[i], d[i], 4'hF, b_acc, e_rd, e_er);
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      exp_mtip = (mt_after(cyc - 1) >= m_cmp);
      n_cmp++;
      if (xint_mtip !== exp_mtip) begin
        n_bad++;
        $display("FAIL mtip_cycle%0d: got %b want %b (mtime %0d)", i, xint_mtip, exp_mtip, mt_after(cyc - 1));
      end
    end
  endtask

  task automatic test_msip();
    logic [31:0] d [3];
    logic [3:0]  w [3];
    logic        old;
    d = '{32'h1, 32'h0, 32'hFFFF_FFFF};
    w = '{4'b0001, 4'b0001, 4'b1110};
    for (int i = 0; i < 3; i++) begin
      old = m_msip;
      bus(32'h0200_0000, d[i], w[i]);
      model_access(32'h0200_0000, d[i], w[i], b_acc, e_rd, e_er);
      n_cmp++; if (b_rd !== 32'h0) begin n_bad++; $display("FAIL msip_wr%0d_rdata: got %h want 0", i, b_rd); end
      n_cmp++; if (b_xm1 !== old) begin n_bad++; $display("FAIL msip_wr%0d_early: got %b want %b", i, b_xm1, old); end
      n_cmp++; if (b_xm2 !== m_msip) begin n_bad++; $display("FAIL msip_wr%0d_out: got %b want %b", i, b_xm2, m_msip); end
    end
    bus(32'h0200_0000, 32'h0, 4'h0);
    model_access(32'h0200_0000, 32'h0, 4'h0, b_acc, e_rd, e_er);
    n_cmp++; if (b_rd !== e_rd) begin n_bad++; $display("FAIL msip_read: got %h want %h", b_rd, e_rd); end
  endtask

  task automatic test_errors();
    logic [31:0] a [5];
    logic [3:0]  w [5];
    a = '{32'h0200_0008, 32'h0200_4002, 32'h0300_0000, 32'h0300_4000, 32'h0200_0001};
    w = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
    for (int i = 0; i < 5; i++) begin
      bus(a[i], 32'h0000_0001, w[i]);
      model_access(a[i], 32'h0000_0001, w[i], b_acc, e_rd, e_er);
      n_cmp++; if (b_r1 !== 1'b1) begin n_bad++; $display("FAIL err%0d_ready: got %b want 1", i, b_r1); end
      n_cmp++; if (b_er !== 1'b1) begin n_bad++; $display("FAIL err%0d_error: got %b want 1", i, b_er); end
      n_cmp++; if (b_rd !== 32'h0) begin n_bad++; $display("FAIL err%0d_rdata: got %h want 0", i, b_rd); end
      n_cmp++; if (b_xm2 !== m_msip) begin n_bad++; $display("FAIL err%0d_msip: got %b want %b", i, b_xm2, m_msip); end
    end
    bus(32'h0200_4000, 32'h0, 4'h0);
    model_access(32'h0200_4000, 32'h0, 4'h0, b_acc, e_rd, e_er);
    n_cmp++; if (b_rd !== 32'd20) begin n_bad++; $display("FAIL err_cmp_kept: got %h want %h", b_rd, 32'd20); end
    n_cmp++; if (b_er !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", b_er); end
  endtask

  task automatic test_carry();
    logic [31:0] exp_hi;
    bus(32'h0200_BFFC, 32'h0, 4'hF);
    model_access(32'h0200_BFFC, 32'h0, 4'hF, b_acc, e_rd, e_er);
    bus(32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF);
    model_access(32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF, b_acc, e_rd, e_er);
    bus(32'h0200_BFF8, 32'h0, 4'h0);
    model_access(32'h0200_BFF8, 32'h0, 4'h0, b_acc, e_rd, e_er);
    n_cmp++; if (b_rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL carry_lo: got %h want ffffffff", b_rd); end
    bus(32'h0200_BFFC, 32'h0, 4'h0);
    model_access(32'h0200_BFFC, 32'h0, 4'h0, b_acc, e_rd, e_er);
`ifdef CLINT_MTIME_LATCH_EN
    exp_hi = 32'h0;
`else
    exp_hi = 32'h1;
`endif
    n_cmp++; if (b_rd !== exp_hi) begin n_bad++; $display("FAIL carry_hi: got %h want %h", b_rd, exp_hi); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    mem_address = 32'h0200_0000;
    mem_wsel    = 4'h0;
    mem_valid   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_rdy = (i % 2 == 0);
      n_cmp++; if (mem_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want %b", i, mem_ready, exp_rdy); end
      if (exp_rdy) begin
        n_cmp++;
        if (mem_rdata !== {31'b0, m_msip}) begin n_bad++; $display("FAIL b2b_rdata%0d: got %h want %h", i, mem_rdata, {31'b0, m_msip}); end
      end
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] offs [9];
    logic [31:0] a, d;
    logic [3:0]  w;
    logic        exp_mtip;
    offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0008, 16'h4002, 16'hBFF9, 16'h1000};
    for (int i = 0; i < 80; i++) begin
      a = {($urandom_range(0, 7) == 0) ? 16'h0300 : 16'h0200, offs[$urandom_range(0, 8)]};
      d = $urandom;
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bus(a, d, w);
      model_access(a, d, w, b_acc, e_rd, e_er);
      exp_mtip = (mt_after(b_acc) >= m_cmp);
      n_cmp++; if (b_r1 !== 1'b1 || b_r2 !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_ready: got %b%b want 10", i, b_r1, b_r2); end
      n_cmp++; if (b_er !== e_er) begin n_bad++; $display("FAIL rnd%0d_error: addr %h got %b want %b", i, a, b_er, e_er); end
      n_cmp++; if (b_rd !== e_rd) begin n_bad++; $display("FAIL rnd%0d_rdata: addr %h got %h want %h", i, a, b_rd, e_rd); end
      n_cmp++; if (b_xm2 !== m_msip) begin n_bad++; $display("FAIL rnd%0d_msip: got %b want %b", i, b_xm2, m_msip); end
      n_cmp++; if (b_mt2 !== exp_mtip) begin n_bad++; $display("FAIL rnd%0d_mtip: got %b want %b", i, b_mt2, exp_mtip); end
    end
  endtask

  task automatic test_reset_mid();
    bus(32'h0200_4004, 32'h0, 4'hF);
    model_access(32'h0200_4004, 32'h0, 4'hF, b_acc, e_rd, e_er);
    bus(32'h0200_4000, 32'h0, 4'hF);
    model_access(32'h0200_4000, 32'h0, 4'hF, b_acc, e_rd, e_er);
    bus(32'h0200_0000, 32'h1, 4'h1);
    model_access(32'h0200_0000, 32'h1, 4'h1, b_acc, e_rd, e_er);
    n_cmp++; if (xint_mtip !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_mtip: got %b want 1", xint_mtip); end
    mem_address = 32'h0200_4000;
    mem_wsel    = 4'h0;
    mem_valid   = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_resp: got %b want 1", mem_ready); end
    rst = 1'b1;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0", mem_ready); end
    n_cmp++; if (xint_mtip !== 1'b0) begin n_bad++; $display("FAIL rstmid_mtip: got %b want 0", xint_mtip); end
    n_cmp++; if (xint_msip !== 1'b0) begin n_bad++; $display("FAIL rstmid_msip: got %b want 0", xint_msip); end
    model_reset(cyc);
    rst = 1'b0;
    bus(32'h0200_4000, 32'h0, 4'h0);
    model_access(32'h0200_4000, 32'h0, 4'h0, b_acc, e_rd, e_er);
    n_cmp++; if (b_rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rstmid_cmp_lo: got %h want ffffffff", b_rd); end
    bus(32'h0200_4004, 32'h0, 4'h0);
    model_access(32'h0200_4004, 32'h0, 4'h0, b_acc, e_rd, e_er);
    n_cmp++; if (b_rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rstmid_cmp_hi: got %h want ffffffff", b_rd); end
    bus(32'h0200_BFF8, 32'h0, 4'h0);
    model_access(32'h0200_BFF8, 32'h0, 4'h0, b_acc, e_rd, e_er);
    n_cmp++; if (b_rd !== e_rd) begin n_bad++; $display("FAIL rstmid_mtime: got %h want %h", b_rd, e_rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mtime_read();
    test_mtip();
    test_msip();
    test_errors();
    test_carry();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
